// File: rtl/motor_pwm_pkg.sv
// Shared types and default timing constants for the motor_pwm servo pulse generator.
package motor_pwm_pkg;

    localparam int unsigned CNT_W             = 21;
    localparam int unsigned DEF_PERIOD_CNT    = 2_000_000;
    localparam int unsigned DEF_PULSE_CW_CNT  = 200_000;
    localparam int unsigned DEF_PULSE_CCW_CNT = 100_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    typedef struct packed {
        logic stop;
        logic cw;
    } motor_cmd_t;

    localparam motor_cmd_t CMD_RESET = '{stop: 1'b1, cw: 1'b1};

endpackage

// File: rtl/pwm_cmd_latch.sv
// Latches the motor command at each period start; MOTOR_PWM_CMD_FILTER_EN requires
// the same command at two consecutive period starts before it is applied.
module pwm_cmd_latch
    import motor_pwm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       latch_en,
    input  motor_cmd_t cmd_sample,
    output motor_cmd_t cmd_next_c,
    output motor_cmd_t cmd_applied
);

`ifdef MOTOR_PWM_CMD_FILTER_EN
    motor_cmd_t cmd_prev;

    // A sample only takes effect when it repeats the previous period's sample.
    always_comb begin
        cmd_next_c = cmd_applied;
        if (cmd_sample == cmd_prev) begin
            cmd_next_c = cmd_sample;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_prev <= CMD_RESET;
        end else if (latch_en) begin
            cmd_prev <= cmd_sample;
        end
    end
`else
    always_comb begin
        cmd_next_c = cmd_sample;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_applied <= CMD_RESET;
        end else if (latch_en) begin
            cmd_applied <= cmd_next_c;
        end
    end

endmodule

// File: rtl/motor_pwm.sv
// Servo PWM generator driven by a shared timebase; optional command filter
// enabled with MOTOR_PWM_CMD_FILTER_EN (implemented in pwm_cmd_latch).
module motor_pwm
    import motor_pwm_pkg::*;
#(
    parameter int unsigned PERIOD_CNT    = DEF_PERIOD_CNT,
    parameter int unsigned PULSE_CW_CNT  = DEF_PULSE_CW_CNT,
    parameter int unsigned PULSE_CCW_CNT = DEF_PULSE_CCW_CNT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] count_in,
    input  logic             motor_reset,
    input  logic             motor_direction,
    output logic             pwm,
    output logic             period_start,
    output logic             running,
    output logic             timebase_err
);

    localparam logic [CNT_W-1:0] PERIOD_LIM = CNT_W'(PERIOD_CNT);
    localparam logic [CNT_W-1:0] WIDTH_CW   = CNT_W'(PULSE_CW_CNT);
    localparam logic [CNT_W-1:0] WIDTH_CCW  = CNT_W'(PULSE_CCW_CNT);

    state_t           state;
    state_t           state_next;
    motor_cmd_t       cmd_sample_c;
    motor_cmd_t       cmd_next_c;
    motor_cmd_t       cmd_applied;
    logic             start_c;
    logic             over_c;
    logic             width_done_c;
    logic [CNT_W-1:0] width_c;

    assign cmd_sample_c = '{stop: motor_reset, cw: motor_direction};
    assign start_c      = (count_in == '0);
    assign over_c       = (count_in > PERIOD_LIM);
    assign width_c      = cmd_applied.cw ? WIDTH_CW : WIDTH_CCW;
    assign width_done_c = (count_in >= width_c);

    pwm_cmd_latch u_cmd_latch (
        .clk         (clk),
        .reset       (reset),
        .latch_en    (start_c),
        .cmd_sample  (cmd_sample_c),
        .cmd_next_c  (cmd_next_c),
        .cmd_applied (cmd_applied)
    );

    // A period start overrides everything, including an unfinished pulse.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, LOW: begin
                if (start_c) begin
                    state_next = cmd_next_c.stop ? LOW : HIGH;
                end
            end
            HIGH: begin
                if (start_c) begin
                    state_next = cmd_next_c.stop ? LOW : HIGH;
                end else if (width_done_c) begin
                    state_next = LOW;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pwm          <= 1'b0;
            period_start <= 1'b0;
            running      <= 1'b0;
            timebase_err <= 1'b0;
        end else begin
            state        <= state_next;
            pwm          <= (state_next == HIGH);
            period_start <= start_c;
            timebase_err <= timebase_err | over_c;
            if (start_c) begin
                running <= ~cmd_next_c.stop;
            end
        end
    end

endmodule

// File: tb/tb_motor_pwm.sv
// Scoreboard bench for motor_pwm with a shortened timebase (period 200, CW 20, CCW 10).
module tb_motor_pwm;

    localparam int P    = 200;
    localparam int WCW  = 20;
    localparam int WCCW = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [20:0] count_in;
    logic        motor_reset = 1'b0;
    logic        motor_direction = 1'b1;
    logic        pwm;
    logic        period_start;
    logic        running;
    logic        timebase_err;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int hi = 0;
    int hi_start = 0;
    int ps_count = 0;
    int ps0 = 0;
    int cnt = 100;
    bit auto_push = 1'b1;
    bit m_stop = 1'b1;
    bit m_cw = 1'b1;
    bit p_stop = 1'b1;
    bit p_cw = 1'b1;

    motor_pwm #(
        .PERIOD_CNT    (P),
        .PULSE_CW_CNT  (WCW),
        .PULSE_CCW_CNT (WCCW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .count_in        (count_in),
        .motor_reset     (motor_reset),
        .motor_direction (motor_direction),
        .pwm             (pwm),
        .period_start    (period_start),
        .running         (running),
        .timebase_err    (timebase_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Command as the spec defines it at a period start; queues the pulse that should follow.
    task automatic model_start(input bit push);
`ifdef MOTOR_PWM_CMD_FILTER_EN
        if (motor_reset == p_stop && motor_direction == p_cw) begin
            m_stop = motor_reset;
            m_cw   = motor_direction;
        end
        p_stop = motor_reset;
        p_cw   = motor_direction;
`else
        m_stop = motor_reset;
        m_cw   = motor_direction;
`endif
        if (push && !m_stop) exp_q.push_back(m_cw ? WCW : WCCW);
    endtask

    task automatic model_reset();
        m_stop = 1'b1;
        m_cw   = 1'b1;
        p_stop = 1'b1;
        p_cw   = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cnt      = (cnt == P) ? 0 : cnt + 1;
        count_in = 21'(cnt);
        if (cnt == 0) model_start(auto_push);
    endtask

    task automatic run_to(input int v);
        for (int i = 0; i < 1000 && cnt != v; i++) step();
    endtask

    task automatic next_period(input bit s, input bit c);
        run_to(P);
        motor_reset     = s;
        motor_direction = c;
        step();
    endtask

    // Monitor: every completed pwm pulse is checked against the queue head.
    always @(negedge clk) begin
        if (period_start) ps_count++;
        if (pwm) begin
            if (hi == 0) hi_start = int'(count_in);
            hi++;
        end else if (hi != 0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse_width", hi, 0);
            end else begin
                int w;
                w = exp_q.pop_front();
                check("pulse_width", hi, w);
                check("pulse_start_count", hi_start, 1);
            end
            hi = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        count_in = 21'(cnt);
        repeat (3) @(posedge clk);
        #1;
        check("reset_pwm", int'(pwm), 0);
        check("reset_period_start", int'(period_start), 0);
        check("reset_running", int'(running), 0);
        check("reset_timebase_err", int'(timebase_err), 0);
        reset = 1'b0;

        // Clockwise, free-running timebase.
        next_period(1'b0, 1'b1);
        next_period(1'b0, 1'b1);
        ps0 = ps_count;
        step();
        step();
        check("running_cw", int'(running), 1);
        run_to(P);
        check("period_start_once_cw", ps_count - ps0, 1);

        // Counter-clockwise, then a direction change in the middle of a pulse.
        next_period(1'b0, 1'b0);
        next_period(1'b0, 1'b0);
        next_period(1'b0, 1'b0);
        run_to(5);
        motor_direction = 1'b1;
        next_period(1'b0, 1'b1);
        next_period(1'b0, 1'b1);

        // Stopped periods; releasing motor_reset mid-period must not start a pulse.
        next_period(1'b1, 1'b1);
        next_period(1'b1, 1'b1);
        ps0 = ps_count;
        step();
        step();
        check("running_stopped", int'(running), 0);
        run_to(100);
        motor_reset = 1'b0;
        run_to(P);
        check("period_start_once_stopped", ps_count - ps0, 1);
        next_period(1'b0, 1'b1);
        next_period(1'b0, 1'b1);

        // Out-of-range timebase value sets a sticky error.
        run_to(100);
        check("err_clear_at_period_boundary", int'(timebase_err), 0);
        @(posedge clk);
        #1;
        count_in = 21'(P + 5);
        step();
        check("err_set", int'(timebase_err), 1);
        next_period(1'b0, 1'b1);
        run_to(100);
        check("err_sticky", int'(timebase_err), 1);

        // Timebase restart at 15 during a CW pulse: 14 + 1 + 20 high cycles.
        auto_push = 1'b0;
        next_period(1'b0, 1'b1);
        auto_push = 1'b1;
        run_to(14);
        @(posedge clk);
        #1;
        cnt      = 0;
        count_in = '0;
        model_start(1'b0);
        exp_q.push_back(35);
        check("pwm_hold_at_restart", int'(pwm), 1);
        step();
        check("pwm_hold_after_restart", int'(pwm), 1);
        next_period(1'b0, 1'b1);

        // Reset asserted mid-pulse at count 12: 11-cycle pulse, pwm drops at once.
        auto_push = 1'b0;
        next_period(1'b0, 1'b1);
        auto_push = 1'b1;
        exp_q.push_back(11);
        run_to(11);
        @(posedge clk);
        #1;
        cnt      = 12;
        count_in = 21'(cnt);
        reset    = 1'b1;
        #1;
        check("pwm_async_reset", int'(pwm), 0);
        model_reset();
        repeat (3) step();
        check("reset_mid_running", int'(running), 0);
        check("reset_mid_err_cleared", int'(timebase_err), 0);
        check("reset_mid_period_start", int'(period_start), 0);
        reset = 1'b0;
        next_period(1'b0, 1'b1);
        next_period(1'b0, 1'b1);
        next_period(1'b0, 1'b1);

        // Single-period stop glitch on the command.
        next_period(1'b1, 1'b1);
        step();
        motor_reset = 1'b0;
        next_period(1'b0, 1'b1);
        next_period(1'b0, 1'b1);
        run_to(P);
        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/motor_pwm.md
MOTOR_PWM -- requirements
Module: motor_pwm

Interface
REQ-001 Parameter PERIOD_CNT, default 2_000_000, timebase counts per servo period (20 ms at 100 MHz).
REQ-002 Parameter PULSE_CW_CNT, default 200_000, high-time counts for clockwise (2 ms).
REQ-003 Parameter PULSE_CCW_CNT, default 100_000, high-time counts for counter-clockwise (1 ms).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 count_in  input  21  shared timebase value; increments by one per clk, returns to 0 after PERIOD_CNT.
REQ-007 motor_reset  input  1  1 = wheel stopped (no pulse this period).
REQ-008 motor_direction  input  1  1 = clockwise, 0 = counter-clockwise.
REQ-009 pwm  output  1  servo control pulse.
REQ-010 period_start  output  1  one-cycle strobe marking a command latch.
REQ-011 running  output  1  latched command is "move" (not stopped).
REQ-012 timebase_err  output  1  sticky flag: count_in exceeded PERIOD_CNT.

Function
REQ-013 State machine SHALL have states IDLE, HIGH, LOW; pwm SHALL be 1 only in HIGH and SHALL be driven from the state register (no combinational path from inputs).
REQ-014 Period start SHALL be the edge at which count_in == 0 is sampled; at that edge motor_reset/motor_direction SHALL be latched and period_start SHALL be 1 for the following cycle only.
REQ-015 At period start with latched motor_reset = 0, next state SHALL be HIGH; with motor_reset = 1, next state SHALL be LOW; running SHALL reflect the latched command from the cycle after the latch.
REQ-016 Pulse width SHALL be PULSE_CW_CNT when latched direction = 1, PULSE_CCW_CNT when 0.
REQ-017 In HIGH, the edge sampling count_in >= width SHALL move to LOW; a contiguous count yields exactly width cycles of pwm = 1, starting one cycle after count_in == 0 is sampled.
REQ-018 In LOW, state SHALL hold until the next period start.
REQ-019 count_in returning to 0 while in HIGH (early timebase reset) SHALL be treated as a new period start: relatch, restart width measurement; pwm SHALL not drop for a cycle if the new command is "move".
REQ-020 Input changes between period starts SHALL have no effect on pwm until the next period start.
REQ-021 Sampling count_in > PERIOD_CNT SHALL set timebase_err, cleared only by reset; pwm behaviour SHALL be unaffected.
REQ-022 Comparisons SHALL be unsigned, 21 bits; parameters exceeding 21 bits are illegal.

Reset
REQ-023 During and after reset: state IDLE, pwm 0, period_start 0, running 0, timebase_err 0, latched command = stopped, clockwise.
REQ-024 Reset asserted mid-pulse SHALL force pwm to 0 asynchronously; after release, first pulse SHALL occur only after the next sampled count_in == 0.
REQ-025 IDLE SHALL transition only on period start, as per REQ-015.

Configuration
REQ-026 With MOTOR_PWM_CMD_FILTER_EN defined, a new command SHALL be applied only when sampled identically at two consecutive period starts; otherwise the previous applied command is reused (period_start still strobes).
REQ-027 Without MOTOR_PWM_CMD_FILTER_EN, the command sampled at each period start SHALL apply immediately.

Structure
REQ-028 Package motor_pwm_pkg SHALL hold the state enum (IDLE, HIGH, LOW) and default constants for PERIOD_CNT, PULSE_CW_CNT, PULSE_CCW_CNT.
REQ-029 One sub-module, pwm_cmd_latch, SHALL own command latching and the optional filter; the FSM and comparators stay in motor_pwm.

Verification
REQ-030 Reset release, motor_reset=0, direction=1, free-running count_in -> pwm high exactly 200_000 cycles per 2_000_001-cycle period, running=1.
REQ-031 direction=0 -> pwm high exactly 100_000 cycles; direction toggled at count_in=50_000 -> current pulse unchanged, next period uses new width.
REQ-032 motor_reset=1 at period start -> pwm 0 for whole period, running=0, period_start still pulses once.
REQ-033 Reset asserted at count_in=120_000 mid-pulse -> pwm 0 same cycle; after release no pulse before next count_in=0.
REQ-034 count_in forced to 0 at 150_000 during CW pulse -> pwm stays 1, new 200_000-cycle pulse measured from the restart.
REQ-035 count_in driven to 2_000_005 -> timebase_err=1 and held until reset; with filter enabled, single-period command glitch -> no change in pwm width.
